// File: rtl/ovi_pkg.sv
// ovi_pkg: shared definitions for the OVI issue path.
//   - field widths of a vector instruction issue (instr / vl / sew)
//   - core_issue_bus / core_completed_bus structs
//   - seq_state_t, the issue sequencer FSM state encoding
//   - OVI_END_INSTR, the instruction value that terminates a program
package ovi_pkg;

   localparam int OVI_INSTR_WIDTH = 32;
   localparam int OVI_VL_WIDTH    = 8;
   localparam int OVI_SEW_WIDTH   = 2;
   // Program entry layout, MSB first: {vl, sew, instr}
   localparam int OVI_ENTRY_WIDTH = OVI_VL_WIDTH + OVI_SEW_WIDTH + OVI_INSTR_WIDTH;

   localparam logic [OVI_INSTR_WIDTH-1:0] OVI_END_INSTR = '1;

   typedef struct packed {
      logic                       valid;
      logic [OVI_INSTR_WIDTH-1:0] instr;
      logic [OVI_VL_WIDTH-1:0]    vl;
      logic [OVI_SEW_WIDTH-1:0]   sew;
   } core_issue_bus;

   typedef struct packed {
      logic valid;
   } core_completed_bus;

   typedef enum logic [1:0] {
      SEQ_IDLE  = 2'd0,
      SEQ_ISSUE = 2'd1,
      SEQ_DRAIN = 2'd2,
      SEQ_DONE  = 2'd3
   } seq_state_t;

   function automatic logic is_end_instr(input logic [OVI_INSTR_WIDTH-1:0] instr);
      return instr == OVI_END_INSTR;
   endfunction

endpackage

// File: rtl/ovi_credit_counter.sv
// ovi_credit_counter: up/down counter of issued-but-uncompleted instructions.
// Ports:
//   clk, rst   clock, synchronous active-high reset (count -> 0)
//   inc        one instruction issued this cycle
//   dec        one instruction completed this cycle
//   count      current number in flight
//   full       count has reached MAX, no further issue allowed
//   underflow  dec without inc while count is 0 (the decrement is dropped)
// inc and dec together leave the count unchanged. The count saturates at MAX
// and at 0.
module ovi_credit_counter #(
   parameter int MAX   = 4,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             underflow
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d   = count_q;
      underflow = 1'b0;
      case ({inc, dec})
         2'b10: begin
            if (count_q != CNT_W'(MAX)) count_d = count_q + CNT_W'(1);
         end
         2'b01: begin
            if (count_q == '0) underflow = 1'b1;
            else               count_d   = count_q - CNT_W'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;
   assign full  = (count_q >= CNT_W'(MAX));

endmodule

// File: rtl/ovi_issue_sequencer.sv
// ovi_issue_sequencer: replays a loaded program of vector instructions into a
// vector core over the OVI issue port, with up to MAX_OUTSTANDING instructions
// in flight and an optional number of repeat passes.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   CORE_HALT         core backpressure, no issue while high
//   CORE_COMPLETED    .valid = one instruction retired this cycle
//   CORE_ISSUE        .valid/.instr/.vl/.sew towards the core
//   PROG_WE/ADDR/DATA program write port, {vl, sew, instr}; IDLE/DONE only
//   START, LOOPS      start pulse (IDLE/DONE only), extra passes after the first
//   BUSY, DONE, ERR   run in progress, run finished, sticky completion underflow
//   ISSUED_CNT        instructions issued in this run, saturating
//   DBG_STATE         FSM state
//   DBG_OUTSTANDING   instructions currently in flight
// Handshake: CORE_ISSUE has no ready. Every cycle with CORE_ISSUE.valid high is
// one accepted instruction; CORE_HALT is the only way the core can stall issue.
// CORE_COMPLETED.valid is likewise a one-cycle, always-accepted event.
module ovi_issue_sequencer
   import ovi_pkg::*;
#(
   parameter int  MEM_DEPTH       = 64,
   parameter int  MAX_OUTSTANDING = 4,
   parameter int  LOOP_W          = 8,
   localparam int PTR_W           = $clog2(MEM_DEPTH),
   localparam int ENTRY_W         = OVI_ENTRY_WIDTH
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                CORE_HALT,
   input  core_completed_bus   CORE_COMPLETED,
   output core_issue_bus       CORE_ISSUE,
   input  logic                PROG_WE,
   input  logic [PTR_W-1:0]    PROG_ADDR,
   input  logic [ENTRY_W-1:0]  PROG_DATA,
   input  logic                START,
   input  logic [LOOP_W-1:0]   LOOPS,
   output logic                BUSY,
   output logic                DONE,
   output logic                ERR,
   output logic [15:0]         ISSUED_CNT,
   output seq_state_t          DBG_STATE,
   output logic [3:0]          DBG_OUTSTANDING
);

   // Power-up contents are all ones so every unwritten entry reads as END.
   // RST deliberately leaves the program intact.
   logic [ENTRY_W-1:0] mem_q [MEM_DEPTH] = '{default: '1};

   seq_state_t          state_q, state_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [LOOP_W-1:0]   loop_rem_q, loop_rem_d;
   logic [15:0]         issued_cnt_q, issued_cnt_d;
   logic                err_q, err_d;

   logic [ENTRY_W-1:0]          entry;
   logic [OVI_INSTR_WIDTH-1:0]  entry_instr;
   logic [OVI_SEW_WIDTH-1:0]    entry_sew;
   logic [OVI_VL_WIDTH-1:0]     entry_vl;
   logic                        entry_is_end;

   logic       issue_ok, issue_valid, end_hit, prog_end, drain_empty;
   logic       credit_full, credit_underflow;
   logic [3:0] outstanding;
   logic       prog_wr_en;

   assign entry        = mem_q[ptr_q];
   assign entry_instr  = entry[OVI_INSTR_WIDTH-1:0];
   assign entry_sew    = entry[OVI_INSTR_WIDTH +: OVI_SEW_WIDTH];
   assign entry_vl     = entry[ENTRY_W-1 -: OVI_VL_WIDTH];
   assign entry_is_end = is_end_instr(entry_instr);

   ovi_credit_counter #(
      .MAX   (MAX_OUTSTANDING),
      .CNT_W (4)
   ) u_credit (
      .clk       (CLK),
      .rst       (RST),
      .inc       (issue_valid),
      .dec       (CORE_COMPLETED.valid),
      .count     (outstanding),
      .full      (credit_full),
      .underflow (credit_underflow)
   );

   // END is only recognised in a cycle that could otherwise issue, so a halted
   // or credit-starved sequencer stays parked on the END entry in ISSUE.
   assign issue_ok    = (state_q == SEQ_ISSUE) && !CORE_HALT && !credit_full;
   assign issue_valid = issue_ok && !entry_is_end;
   assign end_hit     = issue_ok && entry_is_end;
   // Issuing the last array entry ends the pass just like reading END would.
   assign prog_end    = end_hit || (issue_valid && (ptr_q == PTR_W'(MEM_DEPTH - 1)));
   // Looks through a completion arriving this cycle so DONE follows the last
   // completion by one clock.
   assign drain_empty = (outstanding == 4'd0) ||
                        ((outstanding == 4'd1) && CORE_COMPLETED.valid);

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      loop_rem_d   = loop_rem_q;
      issued_cnt_d = issued_cnt_q;
      err_d        = err_q;
      case (state_q)
         SEQ_IDLE, SEQ_DONE: begin
            if (START) begin
               state_d      = SEQ_ISSUE;
               ptr_d        = '0;
               loop_rem_d   = LOOPS;
               issued_cnt_d = '0;
               err_d        = 1'b0;
            end
         end
         SEQ_ISSUE: begin
            if (issue_valid) begin
               ptr_d = ptr_q + PTR_W'(1);
               if (issued_cnt_q != 16'hFFFF) issued_cnt_d = issued_cnt_q + 16'd1;
            end
            if (prog_end) begin
               if (loop_rem_q == '0) begin
                  state_d = SEQ_DRAIN;
               end else begin
                  ptr_d      = '0;
                  loop_rem_d = loop_rem_q - LOOP_W'(1);
               end
            end
         end
         SEQ_DRAIN: begin
            if (drain_empty) state_d = SEQ_DONE;
         end
         default: state_d = SEQ_IDLE;
      endcase
      // A stray completion outranks the clear done by START in the same cycle.
      if (credit_underflow) err_d = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= SEQ_IDLE;
         ptr_q        <= '0;
         loop_rem_q   <= '0;
         issued_cnt_q <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         loop_rem_q   <= loop_rem_d;
         issued_cnt_q <= issued_cnt_d;
         err_q        <= err_d;
      end
   end

   assign prog_wr_en = PROG_WE && ((state_q == SEQ_IDLE) || (state_q == SEQ_DONE));

   always_ff @(posedge CLK) begin
      if (prog_wr_en) mem_q[PROG_ADDR] <= PROG_DATA;
   end

   // Fields follow mem[ptr] even while valid is low.
   assign CORE_ISSUE = '{valid: issue_valid, instr: entry_instr,
                         vl: entry_vl, sew: entry_sew};

   assign BUSY            = (state_q != SEQ_IDLE) && (state_q != SEQ_DONE);
   assign DONE            = (state_q == SEQ_DONE);
   assign ERR             = err_q;
   assign ISSUED_CNT      = issued_cnt_q;
   assign DBG_STATE       = state_q;
   assign DBG_OUTSTANDING = outstanding;

endmodule

// File: tb/tb_ovi_issue_sequencer.sv
// Bench for ovi_issue_sequencer. dut_a uses MAX_OUTSTANDING=4, dut_b uses 1;
// both share the program/start inputs and each has its own core model that
// completes every issued instruction a fixed number of cycles later.
module tb_ovi_issue_sequencer;
   import ovi_pkg::*;

   localparam int ENTRY_W = OVI_ENTRY_WIDTH;
   localparam int DLY_B   = 5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT signals ----------------
   logic               halt_a = 1'b0;
   logic               prog_we = 1'b0;
   logic [5:0]         prog_addr = '0;
   logic [ENTRY_W-1:0] prog_data = '0;
   logic               start = 1'b0;
   logic [7:0]         loops = '0;
   logic               auto_a = 1'b0, man_a = 1'b0, auto_b = 1'b0;

   core_issue_bus     issue_a, issue_b;
   core_completed_bus comp_a, comp_b;
   assign comp_a.valid = auto_a | man_a;
   assign comp_b.valid = auto_b;

   logic       busy_a, done_a, err_a, busy_b, done_b, err_b;
   logic [15:0] cnt_a, cnt_b;
   seq_state_t st_a, st_b;
   logic [3:0] out_a, out_b;

   ovi_issue_sequencer #(.MEM_DEPTH(64), .MAX_OUTSTANDING(4), .LOOP_W(8)) dut_a (
      .CLK(clk), .RST(rst), .CORE_HALT(halt_a), .CORE_COMPLETED(comp_a),
      .CORE_ISSUE(issue_a), .PROG_WE(prog_we), .PROG_ADDR(prog_addr),
      .PROG_DATA(prog_data), .START(start), .LOOPS(loops), .BUSY(busy_a),
      .DONE(done_a), .ERR(err_a), .ISSUED_CNT(cnt_a), .DBG_STATE(st_a),
      .DBG_OUTSTANDING(out_a));

   ovi_issue_sequencer #(.MEM_DEPTH(64), .MAX_OUTSTANDING(1), .LOOP_W(8)) dut_b (
      .CLK(clk), .RST(rst), .CORE_HALT(1'b0), .CORE_COMPLETED(comp_b),
      .CORE_ISSUE(issue_b), .PROG_WE(prog_we), .PROG_ADDR(prog_addr),
      .PROG_DATA(prog_data), .START(start), .LOOPS(loops), .BUSY(busy_b),
      .DONE(done_b), .ERR(err_b), .ISSUED_CNT(cnt_b), .DBG_STATE(st_b),
      .DBG_OUTSTANDING(out_b));

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_err    = 0;
   logic [ENTRY_W-1:0] exp_q_a[$];
   logic [ENTRY_W-1:0] exp_q_b[$];
   int due_a[$], due_b[$];
   int dly_a = 2;
   logic first_b = 1'b0, chk_b_timing = 1'b0;
   int last_comp_b = 0;
   int inflight_b  = 0;

   logic [ENTRY_W-1:0] prog [16];
   logic [ENTRY_W-1:0] end_entry;

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic [ENTRY_W-1:0] mk(input logic [7:0] vl, input logic [1:0] sew,
                                             input logic [31:0] instr);
      return {vl, sew, instr};
   endfunction

   // ---------------- core model + monitor, dut_a ----------------
   always @(negedge clk) begin
      auto_a = 1'b0;
      if (due_a.size() > 0 && due_a[0] == cyc) begin
         void'(due_a.pop_front());
         auto_a = 1'b1;
      end
      if (issue_a.valid) begin
         due_a.push_back(cyc + dly_a);
         if (exp_q_a.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL a_unexpected_issue: got instr %0h, expected no issue (cycle %0d)",
                     issue_a.instr, cyc);
         end else begin
            check("a_issue_entry", {issue_a.vl, issue_a.sew, issue_a.instr},
                  exp_q_a.pop_front());
         end
      end
   end

   // ---------------- core model + monitor, dut_b ----------------
   always @(negedge clk) begin
      auto_b = 1'b0;
      if (due_b.size() > 0 && due_b[0] == cyc) begin
         void'(due_b.pop_front());
         auto_b = 1'b1;
      end
      if (issue_b.valid) begin
         due_b.push_back(cyc + DLY_B);
         if (exp_q_b.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL b_unexpected_issue: got instr %0h, expected no issue (cycle %0d)",
                     issue_b.instr, cyc);
         end else begin
            check("b_issue_entry", {issue_b.vl, issue_b.sew, issue_b.instr},
                  exp_q_b.pop_front());
         end
         inflight_b++;
         check("b_inflight_le1", 64'(inflight_b <= 1), 64'd1);
         if (chk_b_timing) begin
            if (first_b) first_b = 1'b0;
            else         check("b_issue_gap", 64'(cyc - last_comp_b), 64'd1);
         end
      end
      if (auto_b) begin
         last_comp_b = cyc;
         if (inflight_b > 0) inflight_b--;
      end
      if (rst) inflight_b = 0;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic write_entry(input int addr, input logic [ENTRY_W-1:0] data);
      prog_we   = 1'b1;
      prog_addr = 6'(addr);
      prog_data = data;
      tick();
      prog_we = 1'b0;
   endtask

   task automatic load_prog(input int len);
      tick();
      for (int i = 0; i < len; i++) write_entry(i, prog[i]);
      write_entry(len, end_entry);
   endtask

   // Pulses START in the current cycle; returns early in the first run cycle.
   task automatic do_start(input int nloops, input int len);
      for (int p = 0; p <= nloops; p++)
         for (int i = 0; i < len; i++) begin
            exp_q_a.push_back(prog[i]);
            exp_q_b.push_back(prog[i]);
         end
      first_b = 1'b1;
      loops   = 8'(nloops);
      start   = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!(done_a && done_b) && n < 400) begin
         sample();
         n++;
      end
      check({name, "_done"}, 64'(done_a && done_b), 64'd1);
      check({name, "_exp_a_empty"}, 64'(exp_q_a.size()), 64'd0);
      check({name, "_exp_b_empty"}, 64'(exp_q_b.size()), 64'd0);
      check({name, "_err_a"}, 64'(err_a), 64'd0);
      check({name, "_err_b"}, 64'(err_b), 64'd0);
   endtask

   // ---------------- directed tests ----------------
   initial begin
      end_entry = mk(8'd0, 2'd0, 32'hFFFF_FFFF);
      tick();
      tick();
      sample();
      check("rst_valid_a", 64'(issue_a.valid), 64'd0);
      check("rst_busy_a", 64'(busy_a), 64'd0);
      check("rst_done_a", 64'(done_a), 64'd0);
      check("rst_err_a", 64'(err_a), 64'd0);
      check("rst_cnt_a", 64'(cnt_a), 64'd0);
      check("rst_state_a", 64'(st_a), 64'(SEQ_IDLE));
      check("rst_out_a", 64'(out_a), 64'd0);
      check("rst_state_b", 64'(st_b), 64'(SEQ_IDLE));
      tick();
      rst = 1'b0;

      // T1: three back-to-back issues, DONE one clock after the last completion
      for (int i = 0; i < 3; i++) prog[i] = mk(8'd8, 2'd2, 32'h0200_0057 + (32'(i) << 12));
      load_prog(3);
      do_start(0, 3);
      for (int i = 0; i < 3; i++) begin
         sample();
         check("t1_valid_run", 64'(issue_a.valid), 64'd1);
         tick();
      end
      sample();
      check("t1_valid_after_end", 64'(issue_a.valid), 64'd0);
      tick();
      sample();
      check("t1_done_early", 64'(done_a), 64'd0);
      check("t1_busy_drain", 64'(busy_a), 64'd1);
      tick();
      sample();
      check("t1_done", 64'(done_a), 64'd1);
      check("t1_busy_done", 64'(busy_a), 64'd0);
      check("t1_cnt_a", 64'(cnt_a), 64'd3);
      wait_done("t1");
      check("t1_cnt_b", 64'(cnt_b), 64'd3);

      // T2: serial issue on dut_b, next issue one clock after each completion
      for (int i = 0; i < 4; i++) prog[i] = mk(8'd16 + 8'(i), 2'(i), 32'h0300_1057 + 32'(i));
      load_prog(4);
      chk_b_timing = 1'b1;
      do_start(0, 4);
      wait_done("t2");
      chk_b_timing = 1'b0;
      check("t2_cnt_b", 64'(cnt_b), 64'd4);

      // T3: CORE_HALT for ten cycles holds issue and the pointer
      for (int i = 0; i < 6; i++) prog[i] = mk(8'd4, 2'd1, 32'h0400_2057 + (32'(i) << 7));
      load_prog(6);
      do_start(0, 6);
      sample();
      check("t3_first_issue", 64'(issue_a.valid), 64'd1);
      tick();
      halt_a = 1'b1;
      for (int i = 0; i < 10; i++) begin
         sample();
         check("t3_halt_valid", 64'(issue_a.valid), 64'd0);
         if (i == 9) begin
            check("t3_halt_instr", 64'(issue_a.instr), 64'(prog[1][31:0]));
            check("t3_halt_out", 64'(out_a), 64'd0);
         end
         tick();
      end
      halt_a = 1'b0;
      sample();
      check("t3_resume_valid", 64'(issue_a.valid), 64'd1);
      check("t3_resume_instr", 64'(issue_a.instr), 64'(prog[1][31:0]));
      wait_done("t3");

      // T4: two-entry program with LOOPS=2 gives A,B,A,B,A,B
      prog[0] = mk(8'd32, 2'd3, 32'h0500_A057);
      prog[1] = mk(8'd64, 2'd0, 32'h0500_B057);
      load_prog(2);
      do_start(2, 2);
      wait_done("t4");
      check("t4_cnt_a", 64'(cnt_a), 64'd6);
      check("t4_cnt_b", 64'(cnt_b), 64'd6);

      // T5: completion at full credit, then issue+completion in the same cycle
      dly_a = 4;
      for (int i = 0; i < 8; i++) prog[i] = mk(8'd2, 2'd2, 32'h0600_0057 + (32'(i) << 15));
      load_prog(8);
      do_start(0, 8);
      for (int i = 0; i < 4; i++) begin
         sample();
         check("t5_fill_valid", 64'(issue_a.valid), 64'd1);
         tick();
      end
      sample();
      check("t5_full_valid", 64'(issue_a.valid), 64'd0);
      check("t5_full_out", 64'(out_a), 64'd4);
      tick();
      sample();
      check("t5_reissue_valid", 64'(issue_a.valid), 64'd1);
      check("t5_reissue_out", 64'(out_a), 64'd3);
      tick();
      sample();
      check("t5_same_cycle_out", 64'(out_a), 64'd3);
      check("t5_same_cycle_valid", 64'(issue_a.valid), 64'd1);
      wait_done("t5");
      tick();
      man_a = 1'b1;
      tick();
      man_a = 1'b0;
      sample();
      check("t5_stray_err", 64'(err_a), 64'd1);
      check("t5_stray_out", 64'(out_a), 64'd0);
      check("t5_stray_err_b", 64'(err_b), 64'd0);
      repeat (3) tick();
      sample();
      check("t5_err_sticky", 64'(err_a), 64'd1);

      // T6: reset mid-run with writes attempted during ISSUE
      dly_a = 8;
      for (int i = 0; i < 6; i++) prog[i] = mk(8'd1 + 8'(i), 2'd1, 32'h0700_0157 + (32'(i) << 9));
      load_prog(6);
      do_start(0, 6);
      sample();
      check("t6_start_clears_err", 64'(err_a), 64'd0);
      tick();
      write_entry(0, mk(8'hAA, 2'd3, 32'h1234_5678));
      rst = 1'b1;
      sample();
      check("t6_out_before_rst", 64'(out_a), 64'd2);
      check("t6_valid_before_rst", 64'(issue_a.valid), 64'd1);
      tick();
      rst = 1'b0;
      exp_q_a.delete();
      exp_q_b.delete();
      sample();
      check("t6_rst_valid", 64'(issue_a.valid), 64'd0);
      check("t6_rst_busy_a", 64'(busy_a), 64'd0);
      check("t6_rst_busy_b", 64'(busy_b), 64'd0);
      check("t6_rst_out", 64'(out_a), 64'd0);
      check("t6_rst_state", 64'(st_a), 64'(SEQ_IDLE));
      check("t6_mem_kept_a", {issue_a.vl, issue_a.sew, issue_a.instr}, 64'(prog[0]));
      check("t6_mem_kept_b", 64'(issue_b.instr), 64'(prog[0][31:0]));
      repeat (10) tick();
      sample();
      check("t6_late_err_a", 64'(err_a), 64'd1);
      check("t6_late_err_b", 64'(err_b), 64'd1);
      check("t6_late_out", 64'(out_a), 64'd0);
      tick();
      do_start(0, 6);
      sample();
      check("t6_restart_err_a", 64'(err_a), 64'd0);
      check("t6_restart_err_b", 64'(err_b), 64'd0);
      wait_done("t6");
      check("t6_cnt_a", 64'(cnt_a), 64'd6);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_checks);
      $fatal(1);
   end

endmodule
